// File: rtl/csr_trap_ctrl.sv
// Machine-mode CSR sequencer: arbitrates EXU CSR accesses, trap entry and mret,
// runs the mstatus/mepc/mcause update sequences and issues the IFU redirect.
module csr_trap_ctrl #(
  parameter int CSR_ADDR_WIDTH = 12,
  parameter int CSR_DATA_WIDTH = 32,
  parameter logic [CSR_ADDR_WIDTH-1:0] ADDR_MSTATUS = 12'h300,
  parameter logic [CSR_ADDR_WIDTH-1:0] ADDR_MTVEC   = 12'h305,
  parameter logic [CSR_ADDR_WIDTH-1:0] ADDR_MEPC    = 12'h341,
  parameter logic [CSR_ADDR_WIDTH-1:0] ADDR_MCAUSE  = 12'h342
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      inst_csr_valid_i,
  output logic                      inst_csr_ready_o,
  input  logic [CSR_ADDR_WIDTH-1:0] inst_csr_waddr_i,
  input  logic [CSR_DATA_WIDTH-1:0] inst_csr_wdata_i,
  input  logic [CSR_ADDR_WIDTH-1:0] inst_csr_raddr_i,
  output logic [CSR_DATA_WIDTH-1:0] inst_csr_rdata_o,
  input  logic                      trap_valid_i,
  input  logic [CSR_DATA_WIDTH-1:0] trap_pc_i,
  input  logic [CSR_DATA_WIDTH-1:0] trap_cause_i,
  output logic                      trap_ready_o,
  input  logic                      mret_valid_i,
  output logic                      mret_ready_o,
  output logic                      csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_waddr_o,
  output logic [CSR_DATA_WIDTH-1:0] csr_wdata_o,
  output logic [CSR_ADDR_WIDTH-1:0] csr_raddr_o,
  input  logic [CSR_DATA_WIDTH-1:0] csr_rdata_i,
  input  logic [CSR_DATA_WIDTH-1:0] csr_mtvec_i,
  input  logic [CSR_DATA_WIDTH-1:0] csr_mepc_i,
  output logic                      redirect_valid_o,
  output logic [CSR_DATA_WIDTH-1:0] redirect_pc_o,
  output logic                      busy_o
);

  localparam int MIE  = 3;
  localparam int MPIE = 7;

  typedef enum logic [2:0] {
    IDLE, T_EPC, T_CAUSE, T_STATUS, T_JUMP, M_STATUS, M_JUMP
  } state_t;

  state_t                    state, state_nxt;
  logic [CSR_DATA_WIDTH-1:0] pc_q, cause_q;
  logic [CSR_DATA_WIDTH-1:0] status_trap, status_mret;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
    end else begin
      state <= state_nxt;
      if (trap_ready_o) begin
        pc_q    <= trap_pc_i;
        cause_q <= trap_cause_i;
      end
    end
  end

  // mstatus read-modify-write values; csr_raddr_o points at mstatus in both status states
  always_comb begin
    status_trap         = csr_rdata_i;
    status_trap[MPIE]   = csr_rdata_i[MIE];
    status_trap[MIE]    = 1'b0;
    status_trap[12:11]  = 2'b11;
    status_mret         = csr_rdata_i;
    status_mret[MIE]    = csr_rdata_i[MPIE];
    status_mret[MPIE]   = 1'b1;
    status_mret[12:11]  = 2'b11;
  end

  always_comb begin
    state_nxt        = state;
    trap_ready_o     = 1'b0;
    mret_ready_o     = 1'b0;
    inst_csr_ready_o = 1'b0;
    inst_csr_rdata_o = '0;
    csr_we_o         = 1'b0;
    csr_waddr_o      = '0;
    csr_wdata_o      = '0;
    csr_raddr_o      = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    case (state)
      IDLE: begin
        trap_ready_o     = trap_valid_i;
        mret_ready_o     = mret_valid_i && !trap_valid_i;
        inst_csr_ready_o = !trap_valid_i && !mret_valid_i;
        csr_raddr_o      = inst_csr_raddr_i;
        inst_csr_rdata_o = csr_rdata_i;
        if (inst_csr_valid_i && inst_csr_ready_o) begin
          csr_we_o    = 1'b1;
          csr_waddr_o = inst_csr_waddr_i;
          csr_wdata_o = inst_csr_wdata_i;
        end
        if (trap_valid_i)      state_nxt = T_EPC;
        else if (mret_valid_i) state_nxt = M_STATUS;
      end
      T_EPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MEPC;
        csr_wdata_o = pc_q;
        state_nxt   = T_CAUSE;
      end
      T_CAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MCAUSE;
        csr_wdata_o = cause_q;
        state_nxt   = T_STATUS;
      end
      T_STATUS: begin
        csr_raddr_o = ADDR_MSTATUS;
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = status_trap;
        state_nxt   = T_JUMP;
      end
      T_JUMP: begin
        // direct mode only: mode bits are dropped from the vector base
        redirect_valid_o = 1'b1;
        redirect_pc_o    = csr_mtvec_i & ~(CSR_DATA_WIDTH'(3));
        state_nxt        = IDLE;
      end
      M_STATUS: begin
        csr_raddr_o = ADDR_MSTATUS;
        csr_we_o    = 1'b1;
        csr_waddr_o = ADDR_MSTATUS;
        csr_wdata_o = status_mret;
        state_nxt   = M_JUMP;
      end
      M_JUMP: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = csr_mepc_i;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // a reset cycle aborts at once: no handshake, write or redirect escapes
    if (rst_i) begin
      trap_ready_o     = 1'b0;
      mret_ready_o     = 1'b0;
      inst_csr_ready_o = 1'b0;
      csr_we_o         = 1'b0;
      csr_waddr_o      = '0;
      csr_wdata_o      = '0;
      redirect_valid_o = 1'b0;
      redirect_pc_o    = '0;
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: directed test-plan scenarios plus randomized traffic,
// checked every cycle against a transaction-queue model and a behavioural CSR file.
module tb_csr_trap_ctrl;
  logic        clk = 1'b0;
  logic        rst_i;
  logic        inst_csr_valid_i, inst_csr_ready_o;
  logic [11:0] inst_csr_waddr_i, inst_csr_raddr_i;
  logic [31:0] inst_csr_wdata_i, inst_csr_rdata_o;
  logic        trap_valid_i, trap_ready_o, mret_valid_i, mret_ready_o;
  logic [31:0] trap_pc_i, trap_cause_i;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o, csr_raddr_o;
  logic [31:0] csr_wdata_o, csr_rdata_i, csr_mtvec_i, csr_mepc_i;
  logic        redirect_valid_o, busy_o;
  logic [31:0] redirect_pc_o;

  csr_trap_ctrl dut (
    .clk_i(clk), .rst_i(rst_i),
    .inst_csr_valid_i(inst_csr_valid_i), .inst_csr_ready_o(inst_csr_ready_o),
    .inst_csr_waddr_i(inst_csr_waddr_i), .inst_csr_wdata_i(inst_csr_wdata_i),
    .inst_csr_raddr_i(inst_csr_raddr_i), .inst_csr_rdata_o(inst_csr_rdata_o),
    .trap_valid_i(trap_valid_i), .trap_pc_i(trap_pc_i), .trap_cause_i(trap_cause_i),
    .trap_ready_o(trap_ready_o), .mret_valid_i(mret_valid_i), .mret_ready_o(mret_ready_o),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .csr_raddr_o(csr_raddr_o), .csr_rdata_i(csr_rdata_i), .csr_mtvec_i(csr_mtvec_i),
    .csr_mepc_i(csr_mepc_i), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // physical CSR file driven by the DUT write port
  logic [31:0] mem [4096];
  assign csr_rdata_i = mem[csr_raddr_o];
  assign csr_mtvec_i = mem[12'h305];
  assign csr_mepc_i  = mem[12'h341];
  always @(posedge clk) begin
    if (rst_i) begin
      for (int i = 0; i < 4096; i++) mem[i] <= '0;
    end else if (csr_we_o) begin
      mem[csr_waddr_o] <= csr_wdata_o;
    end
  end

  // reference model: shadow CSR contents plus a queue of pending per-cycle actions
  localparam int K_EPC = 0, K_CAUSE = 1, K_TST = 2, K_TJMP = 3, K_MST = 4, K_MJMP = 5;
  typedef struct { int kind; logic [31:0] val; } op_t;
  op_t         q[$];
  logic [31:0] refm [4096];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic e_tr, e_mr, e_ir, e_we, e_rv, e_busy;
    logic [11:0] e_wa;
    logic [31:0] e_wd, e_rp, old;
    op_t op;
    e_tr = 0; e_mr = 0; e_ir = 0; e_we = 0; e_rv = 0;
    e_wa = '0; e_wd = '0; e_rp = '0;
    e_busy = (q.size() != 0);
    if (!rst_i) begin
      if (!e_busy) begin
        e_tr = trap_valid_i;
        e_mr = mret_valid_i && !trap_valid_i;
        e_ir = !trap_valid_i && !mret_valid_i;
        chk("idle_raddr", 32'(csr_raddr_o), 32'(inst_csr_raddr_i));
        chk("idle_rdata", inst_csr_rdata_o, refm[inst_csr_raddr_i]);
        if (inst_csr_valid_i && e_ir) begin
          e_we = 1; e_wa = inst_csr_waddr_i; e_wd = inst_csr_wdata_i;
        end
        if (e_tr) begin
          q.push_back('{K_EPC, trap_pc_i});
          q.push_back('{K_CAUSE, trap_cause_i});
          q.push_back('{K_TST, 32'h0});
          q.push_back('{K_TJMP, 32'h0});
        end else if (e_mr) begin
          q.push_back('{K_MST, 32'h0});
          q.push_back('{K_MJMP, 32'h0});
        end
      end else begin
        op = q.pop_front();
        chk("busy_rdata", inst_csr_rdata_o, 32'h0);
        old = refm[12'h300];
        case (op.kind)
          K_EPC:   begin e_we = 1; e_wa = 12'h341; e_wd = op.val; end
          K_CAUSE: begin e_we = 1; e_wa = 12'h342; e_wd = op.val; end
          K_TST: begin
            e_we = 1; e_wa = 12'h300;
            e_wd = (old & ~32'h1888) | (((old >> 3) & 1) << 7) | 32'h1800;
            chk("tst_raddr", 32'(csr_raddr_o), 32'h300);
          end
          K_MST: begin
            e_we = 1; e_wa = 12'h300;
            e_wd = (old & ~32'h1888) | (((old >> 7) & 1) << 3) | 32'h1880;
            chk("mst_raddr", 32'(csr_raddr_o), 32'h300);
          end
          K_TJMP:  begin e_rv = 1; e_rp = refm[12'h305] & 32'hFFFF_FFFC; end
          default: begin e_rv = 1; e_rp = refm[12'h341]; end
        endcase
      end
    end
    chk("trap_ready", 32'(trap_ready_o), 32'(e_tr));
    chk("mret_ready", 32'(mret_ready_o), 32'(e_mr));
    chk("inst_ready", 32'(inst_csr_ready_o), 32'(e_ir));
    chk("csr_we", 32'(csr_we_o), 32'(e_we));
    chk("csr_waddr", 32'(csr_waddr_o), 32'(e_wa));
    chk("csr_wdata", csr_wdata_o, e_wd);
    chk("redir_valid", 32'(redirect_valid_o), 32'(e_rv));
    chk("redir_pc", redirect_pc_o, e_rp);
    chk("busy", 32'(busy_o), 32'(e_busy));
    if (rst_i) begin
      q.delete();
      for (int i = 0; i < 4096; i++) refm[i] = '0;
    end else if (e_we) begin
      refm[e_wa] = e_wd;
    end
  endtask

  task automatic half(); @(negedge clk); model_step(); endtask
  task automatic next(); @(posedge clk); #1; endtask

  function automatic logic [11:0] pick(input int r);
    case (r % 5)
      0: return 12'h300;
      1: return 12'h305;
      2: return 12'h341;
      3: return 12'h342;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  initial begin
    bit seen;
    bit tr_acc, mr_acc;
    rst_i = 1; inst_csr_valid_i = 0; inst_csr_waddr_i = '0; inst_csr_wdata_i = '0;
    inst_csr_raddr_i = '0; trap_valid_i = 0; trap_pc_i = '0; trap_cause_i = '0; mret_valid_i = 0;
    #1;
    half(); next();
    rst_i = 0;
    half(); chk("lit_reset_busy", 32'(busy_o), 32'h0); next();

    // instruction write to mtvec, then read it back
    inst_csr_valid_i = 1; inst_csr_waddr_i = 12'h305; inst_csr_wdata_i = 32'h8000_0100;
    inst_csr_raddr_i = 12'h305;
    half(); chk("lit_iw_we", 32'(csr_we_o), 32'h1); chk("lit_iw_wdata", csr_wdata_o, 32'h8000_0100); next();
    inst_csr_waddr_i = 12'h300; inst_csr_wdata_i = 32'h0000_0008;
    half(); chk("lit_iw_read", inst_csr_rdata_o, 32'h8000_0100); next();
    inst_csr_valid_i = 0;

    // trap entry
    trap_valid_i = 1; trap_pc_i = 32'h8000_0040; trap_cause_i = 32'd11;
    half(); chk("lit_trap_ready", 32'(trap_ready_o), 32'h1); next();
    trap_valid_i = 0;
    half(); chk("lit_epc_addr", 32'(csr_waddr_o), 32'h341); chk("lit_epc_data", csr_wdata_o, 32'h8000_0040); next();
    half(); chk("lit_cause_addr", 32'(csr_waddr_o), 32'h342); chk("lit_cause_data", csr_wdata_o, 32'hB); next();
    half(); chk("lit_tstatus", csr_wdata_o, 32'h0000_1880); next();
    half(); chk("lit_tjump_v", 32'(redirect_valid_o), 32'h1); chk("lit_tjump_pc", redirect_pc_o, 32'h8000_0100); next();

    // mret
    mret_valid_i = 1;
    half(); chk("lit_mret_ready", 32'(mret_ready_o), 32'h1); next();
    mret_valid_i = 0;
    half(); chk("lit_mstatus", csr_wdata_o, 32'h0000_1888); next();
    half(); chk("lit_mjump_pc", redirect_pc_o, 32'h8000_0040); next();

    // all three requests together: trap wins, the rest wait
    trap_valid_i = 1; trap_pc_i = 32'h8000_0200; trap_cause_i = 32'd3; mret_valid_i = 1;
    inst_csr_valid_i = 1; inst_csr_waddr_i = 12'h342; inst_csr_wdata_i = 32'h5;
    half(); chk("lit_pri_trap", 32'(trap_ready_o), 32'h1); chk("lit_pri_mret", 32'(mret_ready_o), 32'h0);
    chk("lit_pri_inst", 32'(inst_csr_ready_o), 32'h0); next();
    trap_valid_i = 0; seen = 0;
    for (int i = 0; i < 12; i++) begin
      half(); if (mret_ready_o) seen = 1; next();
      if (seen) mret_valid_i = 0;
    end
    chk("lit_mret_eventually", 32'(seen), 32'h1);
    inst_csr_valid_i = 0;
    for (int i = 0; i < 3; i++) begin half(); next(); end

    // mtvec mode bits masked; written the cycle before the trap is accepted
    inst_csr_valid_i = 1; inst_csr_waddr_i = 12'h305; inst_csr_wdata_i = 32'h8000_0103;
    half(); next();
    inst_csr_valid_i = 0; trap_valid_i = 1; trap_pc_i = 32'h8000_0300; trap_cause_i = 32'd2;
    half(); chk("lit_trap2_ready", 32'(trap_ready_o), 32'h1); next();
    trap_valid_i = 0;
    for (int i = 0; i < 3; i++) begin half(); next(); end
    half(); chk("lit_mtvec_mask", redirect_pc_o, 32'h8000_0100); next();

    // reset while in T_CAUSE
    trap_valid_i = 1; trap_pc_i = 32'h8000_0400; trap_cause_i = 32'd7;
    half(); next();
    trap_valid_i = 0;
    half(); next();
    rst_i = 1;
    half(); chk("lit_rst_we", 32'(csr_we_o), 32'h0); chk("lit_rst_redir", 32'(redirect_valid_o), 32'h0); next();
    rst_i = 0;
    half(); chk("lit_rst_busy", 32'(busy_o), 32'h0); chk("lit_rst_redir2", 32'(redirect_valid_o), 32'h0); next();
    for (int i = 0; i < 3; i++) begin half(); next(); end

    // randomized traffic; trap/mret requests are held until accepted
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (trap_valid_i && tr_acc) trap_valid_i = 0;
      else if (!trap_valid_i && $urandom_range(0, 15) == 0) begin
        trap_valid_i = 1; trap_pc_i = $urandom; trap_cause_i = $urandom;
      end
      if (mret_valid_i && mr_acc) mret_valid_i = 0;
      else if (!mret_valid_i && $urandom_range(0, 15) == 0) mret_valid_i = 1;
      inst_csr_valid_i = $urandom_range(0, 1) == 1;
      inst_csr_waddr_i = pick($urandom);
      inst_csr_wdata_i = $urandom;
      inst_csr_raddr_i = pick($urandom);
      rst_i = $urandom_range(0, 199) == 0;
      if (rst_i) begin trap_valid_i = 0; mret_valid_i = 0; end
      half();
      tr_acc = trap_ready_o; mr_acc = mret_ready_o;
      next();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
